// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns (bit0 = A .. bit6 = G),
// the blank pattern and the decoder FSM state type.
package seg_pkg;

    localparam int unsigned NumGlyphs = 16;

    localparam logic [6:0] SegBlank = 7'h7F;

    // Index i holds the pattern that displays hex digit i.
    localparam logic [6:0] SegGlyphs [NumGlyphs] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } seg_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex digit lookup.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] digit_o,
    output logic       is_hex_o,
    output logic       is_blank_o
);

    always_comb begin
        digit_o  = 4'h0;
        is_hex_o = 1'b0;
        for (int i = 0; i < NumGlyphs; i++) begin
            if (pattern_i == SegGlyphs[i]) begin
                digit_o  = 4'(i);
                is_hex_o = 1'b1;
            end
        end
        is_blank_o = (pattern_i == SegBlank);
    end

endmodule

// File: rtl/seg_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment drive by waiting for each
// digit's pattern to settle before capturing it.
module seg_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [6:0]  segIn,
    input  logic        decimalIn,
    input  logic [3:0]  anodeIn,
    output logic [15:0] valueOut,
    output logic [3:0]  digitValidOut,
    output logic [3:0]  dpOut,
    output logic        updateOut,
    output logic        badPatternOut
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    // Sample layout: {anode[3:0], seg[6:0], decimal}
    logic [11:0] smp_d, smp_q;
    logic [11:0] prev_d, prev_q;
    seg_state_e  state_d, state_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [15:0] value_d, value_q;
    logic [3:0]  valid_d, valid_q;
    logic [3:0]  dp_d, dp_q;
    logic        update_d, update_q;
    logic        bad_d, bad_q;

    logic [3:0] anode;
    logic [6:0] seg;
    logic       dec_n;
    logic       changed;
    logic       legal;
    logic       capture;
    logic [1:0] idx;
    logic [3:0] dec_digit;
    logic       is_hex;
    logic       is_blank;

    assign anode = smp_q[11:8];
    assign seg   = smp_q[7:1];
    assign dec_n = smp_q[0];

    seg_pattern_decode u_decode (
        .pattern_i (seg),
        .digit_o   (dec_digit),
        .is_hex_o  (is_hex),
        .is_blank_o(is_blank)
    );

    always_comb begin
        smp_d   = {anodeIn, segIn, decimalIn};
        prev_d  = smp_q;
        changed = (smp_q != prev_q);
        legal   = $onehot(~anode);
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        if (!legal) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else if (changed || state_q == StIdle) begin
            state_d = StSettle;
            cnt_d   = 8'd0;
        end else if (state_q == StSettle) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SettleLast) begin
                capture = 1'b1;
                state_d = StHeld;
            end
        end else if (cnt_q != 8'hFF) begin
            // Held: count saturates so a long-held digit never re-enters the window.
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!anode[i]) begin
                idx = 2'(i);
            end
        end

        value_d = value_q;
        valid_d = valid_q;
        dp_d    = dp_q;
        bad_d   = 1'b0;
        if (capture) begin
            dp_d[idx] = ~dec_n;
            if (is_hex) begin
                value_d[{idx, 2'b00} +: 4] = dec_digit;
                valid_d[idx]               = 1'b1;
            end else if (is_blank) begin
                value_d[{idx, 2'b00} +: 4] = 4'h0;
                valid_d[idx]               = 1'b0;
            end else begin
                valid_d[idx] = 1'b0;
                bad_d        = 1'b1;
            end
        end
        update_d = ({value_d, valid_d, dp_d} != {value_q, valid_q, dp_q});
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            smp_q    <= '1;
            prev_q   <= '1;
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            value_q  <= 16'h0000;
            valid_q  <= 4'b0000;
            dp_q     <= 4'b0000;
            update_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            smp_q    <= smp_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            dp_q     <= dp_d;
            update_q <= update_d;
            bad_q    <= bad_d;
        end
    end

    assign valueOut      = value_q;
    assign digitValidOut = valid_q;
    assign dpOut         = dp_q;
    assign updateOut     = update_q;
    assign badPatternOut = bad_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Self-checking bench for seg_decoder: directed vector table plus latency and reset sequences.
module tb_seg_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic        dec;
    logic [3:0]  anode;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  dp;
    logic        update;
    logic        bad;

    int checks = 0;
    int errors = 0;
    int upd_cnt;
    int bad_cnt;

    typedef struct {
        logic [3:0]  anode;
        logic [6:0]  seg;
        logic        dec;
        int          hold;
        logic [15:0] value;
        logic [3:0]  valid;
        logic [3:0]  dp;
        int          upd;
        int          bad;
    } vec_t;

    localparam int NumVecs = 16;
    vec_t vecs [NumVecs];

    seg_decoder #(.SETTLE_CYCLES(4)) dut (
        .clkIn        (clk),
        .rstIn        (rst),
        .segIn        (seg),
        .decimalIn    (dec),
        .anodeIn      (anode),
        .valueOut     (value),
        .digitValidOut(valid),
        .dpOut        (dp),
        .updateOut    (update),
        .badPatternOut(bad)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (update) upd_cnt++;
        if (bad) bad_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
        anode = a;
        seg   = s;
        dec   = d;
    endtask

    initial begin
        vecs[0]  = '{4'b1110, 7'h79, 1'b1, 8,  16'h0001, 4'b0001, 4'b0000, 1, 0};
        vecs[1]  = '{4'b1101, 7'h30, 1'b1, 8,  16'h0031, 4'b0011, 4'b0000, 1, 0};
        vecs[2]  = '{4'b1011, 7'h12, 1'b1, 8,  16'h0531, 4'b0111, 4'b0000, 1, 0};
        vecs[3]  = '{4'b0111, 7'h0E, 1'b1, 8,  16'hF531, 4'b1111, 4'b0000, 1, 0};
        vecs[4]  = '{4'b1110, 7'h79, 1'b1, 8,  16'hF531, 4'b1111, 4'b0000, 0, 0};
        vecs[5]  = '{4'b1101, 7'h30, 1'b1, 8,  16'hF531, 4'b1111, 4'b0000, 0, 0};
        vecs[6]  = '{4'b1011, 7'h12, 1'b1, 8,  16'hF531, 4'b1111, 4'b0000, 0, 0};
        vecs[7]  = '{4'b0111, 7'h0E, 1'b1, 8,  16'hF531, 4'b1111, 4'b0000, 0, 0};
        // Two-sample glitch of 19 on digit 1, then a settled 40
        vecs[8]  = '{4'b1101, 7'h19, 1'b1, 2,  16'hF531, 4'b1111, 4'b0000, 0, 0};
        vecs[9]  = '{4'b1101, 7'h40, 1'b1, 8,  16'hF501, 4'b1111, 4'b0000, 1, 0};
        vecs[10] = '{4'b1011, 7'h55, 1'b1, 8,  16'hF501, 4'b1011, 4'b0000, 1, 1};
        vecs[11] = '{4'b1011, 7'h7F, 1'b1, 8,  16'hF001, 4'b1011, 4'b0000, 1, 0};
        vecs[12] = '{4'b0111, 7'h0E, 1'b0, 8,  16'hF001, 4'b1011, 4'b1000, 1, 0};
        vecs[13] = '{4'b1100, 7'h24, 1'b1, 10, 16'hF001, 4'b1011, 4'b1000, 0, 0};
        vecs[14] = '{4'b1111, 7'h24, 1'b1, 10, 16'hF001, 4'b1011, 4'b1000, 0, 0};
        vecs[15] = '{4'b0111, 7'h0E, 1'b0, 8,  16'hF001, 4'b1011, 4'b1000, 0, 0};

        rst = 1'b1;
        drive(4'b1111, 7'h7F, 1'b1);
        upd_cnt = 0;
        bad_cnt = 0;
        tick();
        tick();
        check("reset value", 32'(value), 32'h0000);
        check("reset valid", 32'(valid), 32'h0);
        check("reset dp", 32'(dp), 32'h0);
        check("reset update", 32'(update), 32'h0);
        check("reset bad", 32'(bad), 32'h0);
        rst = 1'b0;

        // Latency: pulse exactly on the sixth edge after applying the inputs
        drive(4'b1110, 7'h24, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("latency update edge %0d", k), 32'(update), 32'(k == 6));
        end
        check("latency value", 32'(value), 32'h0002);
        check("latency valid", 32'(valid), 32'h1);

        for (int v = 0; v < NumVecs; v++) begin
            drive(vecs[v].anode, vecs[v].seg, vecs[v].dec);
            upd_cnt = 0;
            bad_cnt = 0;
            for (int c = 0; c < vecs[v].hold; c++) tick();
            check($sformatf("vec%0d value", v), 32'(value), 32'(vecs[v].value));
            check($sformatf("vec%0d valid", v), 32'(valid), 32'(vecs[v].valid));
            check($sformatf("vec%0d dp", v), 32'(dp), 32'(vecs[v].dp));
            check($sformatf("vec%0d updates", v), upd_cnt, vecs[v].upd);
            check($sformatf("vec%0d bads", v), bad_cnt, vecs[v].bad);
        end

        // Reset lands on the edge that would capture 24 on digit 0
        drive(4'b1110, 7'h24, 1'b1);
        upd_cnt = 0;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        check("rst capture value", 32'(value), 32'h0000);
        check("rst capture valid", 32'(valid), 32'h0);
        check("rst capture dp", 32'(dp), 32'h0);
        check("rst capture updates", upd_cnt, 0);
        rst = 1'b0;

        // After release a full fresh window is needed
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("post-reset update edge %0d", k), 32'(update), 32'(k == 6));
        end
        check("post-reset value", 32'(value), 32'h0002);
        check("post-reset valid", 32'(valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
